// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, the fetch-buffer entry
// layout, the default reset PC and small PC helper functions.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  // Default first fetch address after reset
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One decode-side buffer entry: the fetched word and the address it came from
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Sequential next PC; wraps naturally from 32'hFFFF_FFFC to 0
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  // Force a target onto a word boundary
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries for decode.
// Flush empties it in one cycle and wins over push and pop. A push while
// full is only honoured together with a pop, so no entry is ever lost.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && (!w_full || w_do_pop) && !flush;

  // Entry storage: written on an accepted push, contents need no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush returns to the empty state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues at most one request to
// instruction memory at a time, buffers in-order responses for decode and
// handles branch/jump redirects (flush plus discard of a response in flight).
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target raises a sticky fetch_misalign flag and halts
// fetching until the next aligned redirect; otherwise targets are silently
// word-aligned and fetch_misalign is tied low.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic               fetch_misalign
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_outstanding;
  logic            r_discard;

  logic             w_rsp_fire;
  logic             w_req_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_halted;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic [XLEN-1:0]  w_redirect_target;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign_halt;
  logic w_redirect_bad;

  assign w_redirect_target = redirect_pc;
  assign w_redirect_bad    = (redirect_pc[1:0] != 2'b00);
  assign w_halted          = r_misalign_halt;
  assign fetch_misalign    = r_misalign_halt;

  // Sticky misalignment flag doubles as the halt: set by a misaligned
  // redirect, cleared only by the next aligned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_halt <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign_halt <= w_redirect_bad;
    end
  end
`else
  assign w_redirect_target = align_pc(redirect_pc);
  assign w_halted          = 1'b0;
  assign fetch_misalign    = 1'b0;
`endif

  // A response only counts while a request is actually outstanding; this also
  // ignores anything arriving during reset
  assign w_rsp_fire = imem_rsp_valid && r_outstanding;

  // Entries already buffered plus the one that may still come back
  assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(r_outstanding);

  // Issue only when the single request slot is (or is becoming) free, the
  // buffer can take the answer, no redirect is in progress and not halted
  assign imem_req_valid = rst_n
                       && (!r_outstanding || w_rsp_fire)
                       && (w_occupancy < (CNT_W + 1)'(BUF_DEPTH))
                       && !redirect_valid
                       && !w_halted;
  assign imem_addr  = r_pc;
  assign w_req_fire = imem_req_valid && imem_req_ready;

  // A redirect in the same cycle as a response drops that response
  assign w_push      = w_rsp_fire && !r_discard && !redirect_valid;
  assign w_push_data = '{instr: imem_rdata, pc: r_req_pc};
  assign w_pop       = id_valid && id_ready;

  // PC, outstanding-request tracking and discard of stale responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
      // A response still on its way belongs to the old path: keep the slot
      // busy but mark it for dropping. One arriving now is simply dropped.
      r_outstanding <= r_outstanding && !imem_rsp_valid;
      r_discard     <= r_outstanding && !imem_rsp_valid;
    end else begin
      if (w_rsp_fire) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
      // A new accept in the same cycle as a response re-arms the slot
      if (w_req_fire) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_pc;
        r_pc          <= pc_plus4(r_pc);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign id_valid = !w_empty;
  assign id_instr = w_head.instr;
  assign id_pc    = w_head.pc;

endmodule
